// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : UART receiver driven by a 16x baud tick. Synchronises the rx
//               line, detects start bits, majority-votes three mid-bit samples
//               (tick 7, 8, 9 of each bit) and delivers LSB-first frames with
//               optional parity as one-clock result pulses.
// Ports       : clk, rst (async, active-high)
//               i_tick_16x      1-clk pulse at 16x baud
//               i_rx            asynchronous serial input, idle high
//               o_rx_data       last completed data word (errored ones too)
//               o_rx_valid      1-clk pulse, error-free frame in o_rx_data
//               o_framing_error 1-clk pulse, stop bit sampled low
//               o_parity_error  1-clk pulse, parity mismatch with good stop
//               o_busy          high whenever a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick_16x,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_framing_error,
    output logic                 o_parity_error,
    output logic                 o_busy
);

    localparam int                 c_IDX_W    = $clog2(DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
    localparam logic [3:0]         c_SMP_A    = 4'd7;
    localparam logic [3:0]         c_SMP_B    = 4'd8;
    localparam logic [3:0]         c_SMP_DEC  = 4'd9;
    localparam logic [3:0]         c_SMP_LAST = 4'd15;
    localparam logic               c_ODD      = 1'(PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [3:0]           r_smp_cnt;
    logic                 r_smp_a;
    logic                 r_smp_b;
    logic                 r_armed;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_framing_error;
    logic                 r_parity_error;

    logic w_start;
    logic w_dec_tick;
    logic w_wrap;
    logic w_vote;
    logic w_stop_dec;
    logic w_parity_ok;
    logic w_frame_good;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Third sample is the live synchronised value on the decision tick.
    assign w_vote       = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);
    assign w_start      = i_tick_16x && r_armed && !r_rx_s;
    assign w_dec_tick   = i_tick_16x && (r_smp_cnt == c_SMP_DEC);
    assign w_wrap       = i_tick_16x && (r_smp_cnt == c_SMP_LAST);
    assign w_stop_dec   = (r_state == S_STOP) && w_dec_tick;
    assign w_parity_ok  = ((^r_shift) ^ r_parity) == c_ODD;
    assign w_frame_good = (PARITY_EN == 0) || w_parity_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A high vote mid start bit was only a glitch on the line.
                if (w_dec_tick && w_vote) begin
                    w_state_next = S_IDLE;
                end else if (w_wrap) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap && (r_bit_idx == c_LAST_IDX)) begin
                    w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at the stop decision so a back-to-back start edge is not missed.
                if (w_dec_tick) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp_cnt       <= '0;
            r_smp_a         <= 1'b1;
            r_smp_b         <= 1'b1;
            r_armed         <= 1'b0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_parity        <= 1'b0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_framing_error <= 1'b0;
            r_parity_error  <= 1'b0;
        end else begin
            r_rx_valid      <= 1'b0;
            r_framing_error <= 1'b0;
            r_parity_error  <= 1'b0;
            if (i_tick_16x) begin
                if ((r_state == S_IDLE) || (w_state_next == S_IDLE)) begin
                    r_smp_cnt <= '0;
                end else begin
                    r_smp_cnt <= r_smp_cnt + 4'd1;
                end
                if (r_smp_cnt == c_SMP_A) begin
                    r_smp_a <= r_rx_s;
                end
                if (r_smp_cnt == c_SMP_B) begin
                    r_smp_b <= r_rx_s;
                end
                // Arming needs a high line first, so a stuck-low line cannot retrigger.
                if (r_state == S_IDLE) begin
                    if (w_start) begin
                        r_armed <= 1'b0;
                    end else if (r_rx_s) begin
                        r_armed <= 1'b1;
                    end
                end
                if ((r_state == S_DATA) && w_dec_tick) begin
                    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                end
                if ((r_state == S_DATA) && w_wrap) begin
                    r_bit_idx <= (r_bit_idx == c_LAST_IDX) ? '0 : r_bit_idx + c_IDX_W'(1);
                end
                if ((r_state == S_PARITY) && w_dec_tick) begin
                    r_parity <= w_vote;
                end
                if (w_stop_dec) begin
                    r_rx_data <= r_shift;
                    if (!w_vote) begin
                        r_framing_error <= 1'b1;
                    end else if (!w_frame_good) begin
                        r_parity_error <= 1'b1;
                    end else begin
                        r_rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_rx_data       = r_rx_data;
    assign o_rx_valid      = r_rx_valid;
    assign o_framing_error = r_framing_error;
    assign o_parity_error  = r_parity_error;

endmodule
`default_nettype wire
